// File: rtl/cla_seq_defs_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width,
// and small helpers used by the sequencer.
package cla_seq_defs;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A counter always needs at least one bit, even when there is one slice.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder slice: generate/propagate terms
// with all internal carries expanded from cin in parallel.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = 4'b0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder: one cla4 slice reused NSLICE times, LSB nibble
// first, with a registered inter-slice carry and valid/ready on both sides.
module cla_seq_adder
  import cla_seq_defs::*;
#(
  parameter  int WIDTH  = 16,
  localparam int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             CNT_W = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  cla4 u_slice (
    .a    (a_sh_q[SLICE_W-1:0]),
    .b    (b_sh_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN: begin
        // Each slice result enters from the top so the LSB nibble ends at the bottom.
        sum_d   = (sum_q >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));
        a_sh_d  = a_sh_q >> SLICE_W;
        b_sh_d  = b_sh_q >> SLICE_W;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = slice_cout;
          ovf_d   = add_ovf(a_msb_q, b_msb_q, slice_sum[SLICE_W-1]);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept applies from IDLE or as a back-to-back handoff out of DONE.
    if (in_valid && in_ready) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (WIDTH=16): directed cases plus a random
// regression checked against an integer-arithmetic reference model.
module tb_cla_seq_adder;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   u;
    int   s;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.sum  = u[W-1:0];
    e.cout = (u > 32'h0000_FFFF);
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: a result is consumed on an edge where out_valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: got sum=%h cout=%b ovf=%b, expected no output",
                   sum, cout, ovf);
        end else begin
          e = sb.pop_front();
          if ({cout, ovf, sum} !== {e.cout, e.ovf, e.sum}) begin
            n_fail++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present an operation and hold it until the DUT accepts; returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    bit done;
    done = 1'b0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(x, y, c));
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || out_valid) && i < 300) begin
      tick();
      i++;
    end
    check("drain_timeout", 32'(sb.size() != 0 || out_valid), 32'd0);
  endtask

  initial begin
    int lat;

    // Reset state
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout_ovf",  32'({cout, ovf}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic add and accept-to-valid latency
    send(16'h0001, 16'h0002, 1'b0);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      tick();
      if (out_valid) lat = n;
    end
    check("latency", 32'(lat), 32'd4);
    drain();
    check("idle_hold_sum", 32'(sum), 32'h0003);

    // Carry rippling through every slice, then signed overflow both directions
    send(16'hFFFF, 16'h0001, 1'b0); drain();
    check("ripple_cout", 32'({cout, sum}), 32'h1_0000);
    send(16'h7FFF, 16'h0001, 1'b0); drain();
    check("pos_ovf", 32'({cout, ovf, sum}), 32'h1_8000);
    send(16'h8000, 16'h8000, 1'b0); drain();
    check("neg_ovf", 32'({cout, ovf, sum}), 32'h3_0000);

    // Backpressure with ignored in_valid pulses, then same-edge handoff
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      check("bp_sum",      32'(sum),       32'h5556);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      check("bp_valid",    32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0);
    drain();
    check("handoff_sum", 32'({cout, sum}), 32'h0_0100);

    // Reset during the second RUN cycle
    send(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_outputs",  32'({out_valid, cout, ovf, sum}), 32'd0);
    tick();
    rst = 1'b0;
    send(16'h0009, 16'h0006, 1'b0); drain();
    check("post_rst_sum", 32'({cout, sum}), 32'h0_000F);

    // Random regression with random gaps and random out_ready
    rand_ready = 1'b1;
    for (int k = 0; k < 500; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle wide adder controller that sequences a single 4-bit carry-lookahead slice (cla4) across a WIDTH-bit operand, one nibble per cycle, LSB nibble first.
- Registers the carry between slices and runs a small FSM with valid/ready handshakes on the input and output sides.
- Sits beside the combinational cla4 as the area-saving alternative to a full-width CLA tree.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; not user-overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and cin are presented
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result is valid and held
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  A+B+cin, modulo 2^WIDTH
- cout  output  1  unsigned carry-out of the full WIDTH
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - FSM = IDLE; in_ready = 1; out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - Internal operand shift registers, carry register and slice counter all = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. When in_valid is high, on the clock edge:
  - latch a, b and cin (cin into the carry register);
  - latch a[WIDTH-1] and b[WIDTH-1] for ovf;
  - clear the counter; go to RUN.
- RUN: in_ready = 0, out_valid = 0. Each cycle:
  - cla4 adds the low nibbles of the a/b shift registers plus the carry register;
  - the 4-bit result shifts into sum from the top (sum >> 4, result into [WIDTH-1:WIDTH-4]);
  - a/b registers shift right by 4; carry register <= slice cout; counter increments.
  - When counter == NSLICE-1, that edge's update is the last one; go to DONE.
- Latency: accept at edge k means RUN covers the N cycles following edge k; out_valid is high after edge k+NSLICE. For WIDTH=16, out_valid rises 4 cycles after the accept edge.
- DONE:
  - out_valid = 1; cout = carry register; ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
  - sum, cout and ovf stay stable while out_ready = 0.
  - in_ready = out_ready, so throughput is one operation per NSLICE+1 cycles.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid drops next cycle; sum/cout/ovf keep their last values.
  - out_ready=1 and in_valid=1: accept the new operands on the same edge and go straight to RUN.
- Operand stability: a, b and cin are sampled only on the accept edge. Changes at any other time have no effect.
- in_valid is ignored during RUN (in_ready = 0). The bench must not count those cycles as accepted.
- Reset mid-RUN or mid-DONE: immediately returns every output and register to its reset value; the in-flight operation is discarded.
- WIDTH=4 (NSLICE=1): RUN lasts exactly one cycle.
- Counter width: $clog2(NSLICE), minimum 1 bit.

Decomposition:
- Shared package/header cla_seq_defs holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - SLICE_W = 4.
- The one sub-module is the existing cla4, instantiated once as the slice datapath. All sequencing, shifting and the carry register live in cla_seq_adder.

Test Plan (WIDTH=16):
- 0x0001 + 0x0002, cin=0 → sum=0x0003, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 slices).
- 0x7FFF + 0x0001, cin=0 → sum=0x8000, cout=0, ovf=1; then 0x8000 + 0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure on 0x1234 + 0x4321, cin=1 with out_ready low for 5 cycles:
  - sum=0x5556 stays stable; in_ready stays 0; in_valid pulses are ignored.
  - Raising out_ready together with in_valid (0x00FF + 0x0001) accepts the new operation on the same edge; result is 0x0100.
- Assert rst for 1 cycle during the 2nd RUN cycle:
  - all outputs go to 0 immediately and in_ready goes to 1;
  - a following 0x0009 + 0x0006 yields 0x000F, cout=0.
- Random regression: 500 operations with random out_ready/in_valid gaps; every result matches {cout,sum} = a+b+cin, and each op's ovf matches the sign rule.
